// File: rtl/life_seq_ctrl.sv
// life_seq_ctrl: seeds the 8x8 life array one 4x4 tile per cycle, then paces
// generation steps and slots host tile writes so a write and a step never share a cycle.
module life_seq_ctrl #(
   parameter logic [15:0] INIT_0 = 16'h0000,
   parameter logic [15:0] INIT_1 = 16'h0000,
   parameter logic [15:0] INIT_2 = 16'h0000,
   parameter logic [15:0] INIT_3 = 16'h0000,
   parameter int          DIV_W  = 24
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             run,
   input  logic             single,
   input  logic [DIV_W-1:0] period,
   input  logic             host_wr,
   input  logic [1:0]       host_tile,
   input  logic [15:0]      host_data,
   output logic             host_ack,
   output logic [15:0]      vali,
   output logic [1:0]       vali_selector,
   output logic             write_enb,
   output logic             step,
   output logic [15:0]      gen_count,
   output logic             busy
);

   typedef enum logic [1:0] {LOAD, READY, WRITE} state_t;

   state_t           state, state_n;
   logic [1:0]       load_idx, load_idx_n;
   logic [DIV_W-1:0] div_cnt, div_n, term;
   logic             pending, pending_n;
   logic             req;
   logic             write_now;
   logic [15:0]      vali_n, gen_n;
   logic [1:0]       sel_n;
   logic             we_n, ack_n, step_n, busy_n;

   function automatic logic [15:0] init_tile(input logic [1:0] idx);
      case (idx)
         2'd0:    return INIT_0;
         2'd1:    return INIT_1;
         2'd2:    return INIT_2;
         default: return INIT_3;
      endcase
   endfunction

   // A period of zero behaves like one: the divider wraps every cycle.
   always_comb begin
      if (period == '0) term = '0;
      else              term = period - DIV_W'(1);
   end

   assign write_now = (state == WRITE);

   always_comb begin
      state_n    = state;
      load_idx_n = load_idx;
      div_n      = div_cnt;
      pending_n  = pending;
      req        = 1'b0;
      vali_n     = vali;
      sel_n      = vali_selector;
      we_n       = 1'b0;
      ack_n      = 1'b0;
      step_n     = 1'b0;
      gen_n      = gen_count;
      busy_n     = 1'b0;
      case (state)
         LOAD: begin
            we_n       = 1'b1;
            sel_n      = load_idx;
            vali_n     = init_tile(load_idx);
            busy_n     = 1'b1;
            div_n      = '0;
            pending_n  = 1'b0;
            load_idx_n = load_idx + 2'd1;
            if (load_idx == 2'd3) state_n = READY;
         end
         default: begin
            if (run) begin
               if (div_cnt == term) begin
                  div_n = '0;
                  req   = 1'b1;
               end else begin
                  div_n = div_cnt + DIV_W'(1);
               end
            end else begin
               div_n = '0;
               req   = single;
            end
            // Host data is latched onto the array bus at acceptance; the strobe follows a cycle later.
            if (write_now) begin
               we_n    = 1'b1;
               ack_n   = 1'b1;
               state_n = READY;
            end else if (host_wr && !host_ack) begin
               state_n = WRITE;
               vali_n  = host_data;
               sel_n   = host_tile;
            end
            if (pending && !write_now) begin
               step_n = 1'b1;
               gen_n  = gen_count + 16'd1;
            end
            pending_n = (pending && write_now) || req;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= LOAD;
         load_idx      <= 2'd0;
         div_cnt       <= '0;
         pending       <= 1'b0;
         vali          <= 16'h0000;
         vali_selector <= 2'd0;
         write_enb     <= 1'b0;
         host_ack      <= 1'b0;
         step          <= 1'b0;
         gen_count     <= 16'h0000;
         busy          <= 1'b1;
      end else begin
         state         <= state_n;
         load_idx      <= load_idx_n;
         div_cnt       <= div_n;
         pending       <= pending_n;
         vali          <= vali_n;
         vali_selector <= sel_n;
         write_enb     <= we_n;
         host_ack      <= ack_n;
         step          <= step_n;
         gen_count     <= gen_n;
         busy          <= busy_n;
      end
   end

endmodule
